// File: rtl/pwm_seq_pkg.sv
// ----------------------------------------------------------------------------
// pwm_seq_pkg
// Shared types and constants for the PWM start sequencer.
//   seq_state_e   : sequencer FSM state encoding (3 bits)
//   CH_W          : width of the channel index field of a command
//   CMD_W         : packed command width for the default gap width
//   DROP_CNT_MAX  : saturation value of the dropped-command counter
//   cmd_width()   : packed command width for an arbitrary gap width
// ----------------------------------------------------------------------------
package pwm_seq_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CHECK    = 3'd1,
        START    = 3'd2,
        WAIT_ACK = 3'd3,
        GAP      = 3'd4
    } seq_state_e;

    localparam int         CH_W          = 8;
    localparam int         GAP_W_DEFAULT = 16;
    localparam int         CMD_W         = CH_W + GAP_W_DEFAULT;
    localparam logic [7:0] DROP_CNT_MAX  = 8'd255;

    // Command word is {channel, gap}; channel occupies the upper CH_W bits.
    function automatic int cmd_width(input int gap_w);
        return CH_W + gap_w;
    endfunction

endpackage

// File: rtl/pwm_seq_if.sv
// ----------------------------------------------------------------------------
// pwm_seq_if
// Command handshake between the UART register mapper (master) and the
// PWM start sequencer (slave).
//   cmd_valid : command present                     (master -> slave)
//   cmd_ch    : target channel index, 8 bits        (master -> slave)
//   cmd_gap   : post-acknowledge idle cycles        (master -> slave)
//   cmd_ready : sequencer can accept a command      (slave -> master)
// ----------------------------------------------------------------------------
interface pwm_seq_if #(
    parameter int GAP_WIDTH = 16
);
    logic                 cmd_valid;
    logic [7:0]           cmd_ch;
    logic [GAP_WIDTH-1:0] cmd_gap;
    logic                 cmd_ready;

    modport master (output cmd_valid, cmd_ch, cmd_gap, input  cmd_ready);
    modport slave  (input  cmd_valid, cmd_ch, cmd_gap, output cmd_ready);
endinterface

// File: rtl/pwm_seq_fifo.sv
// ----------------------------------------------------------------------------
// pwm_seq_fifo
// Synchronous show-ahead FIFO with registered full/empty flags.
//   clk_50M  : clock
//   rst_n    : synchronous active-low reset (empties the FIFO)
//   push     : write wr_data (ignored when full)
//   wr_data  : data to write
//   pop      : advance the head (ignored when empty)
//   rd_data  : current head entry, valid while !empty
//   full     : registered full flag
//   empty    : registered empty flag
//   level    : current occupancy, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
// ----------------------------------------------------------------------------
module pwm_seq_fifo
    import pwm_seq_pkg::*;
#(
    parameter int WIDTH = CMD_W,
    parameter int DEPTH = 4
) (
    input  logic                     clk_50M,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    level_q;
    logic [LW-1:0]    level_d;
    logic             full_q;
    logic             empty_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full_q;
    assign do_pop  = pop  && !empty_q;

    // NOTE: every variable written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        level_d = level_q;
        if (do_push && !do_pop) begin
            level_d = level_q + 1'b1;
        end else if (!do_push && do_pop) begin
            level_d = level_q - 1'b1;
        end
    end

    // NOTE: storage has no reset; only pointers and flags define what is valid,
    // which keeps the array a plain RAM with no reset fan-out.
    always_ff @(posedge clk_50M) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_50M) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            level_q <= level_d;
            full_q  <= (level_d == LW'(DEPTH));
            empty_q <= (level_d == '0);
        end
    end

    assign rd_data = mem[rd_ptr];
    assign full    = full_q;
    assign empty   = empty_q;
    assign level   = level_q;

endmodule

// File: rtl/pwm_start_sequencer.sv
// ----------------------------------------------------------------------------
// pwm_start_sequencer
// Queues {channel, gap} start commands and issues each one as a single-cycle
// one-hot start pulse once the target PWM channel is idle, then waits for the
// channel to report busy and holds off the next start for 'gap' cycles.
//   clk_50M     : system clock
//   rst_n       : synchronous active-low reset
//   cmd         : command handshake (pwm_seq_if.slave)
//   ch_busy     : per-channel busy flags from the PWM generators
//   ch_start    : registered one-hot start pulse
//   seq_busy    : FSM active or commands queued
//   fifo_level  : command FIFO occupancy
//   err_bad_ch  : pulse, command dropped for an out-of-range channel
//   err_timeout : pulse, acknowledge timeout (tied low unless enabled)
//   drop_cnt    : saturating dropped-command counter
// Optional feature macro: PWM_SEQ_ACK_TIMEOUT_EN enables the WAIT_ACK timer
// that aborts a start which is never acknowledged within _ACK_TIMEOUT cycles.
// ----------------------------------------------------------------------------
module pwm_start_sequencer
    import pwm_seq_pkg::*;
#(
    parameter int _NUM_CHANNELS = 3,
    parameter int _FIFO_DEPTH   = 4,
    parameter int _GAP_WIDTH    = 16,
    parameter int _ACK_TIMEOUT  = 1023
) (
    input  logic                           clk_50M,
    input  logic                           rst_n,
    pwm_seq_if.slave                       cmd,
    input  logic [_NUM_CHANNELS-1:0]       ch_busy,
    output logic [_NUM_CHANNELS-1:0]       ch_start,
    output logic                           seq_busy,
    output logic [$clog2(_FIFO_DEPTH):0]   fifo_level,
    output logic                           err_bad_ch,
    output logic                           err_timeout,
    output logic [7:0]                     drop_cnt
);
    localparam int CW = cmd_width(_GAP_WIDTH);

    // Elaboration-time parameter sanity checks.
    if (_NUM_CHANNELS < 1 || _NUM_CHANNELS > 8) begin : g_chk_ch
        $error("_NUM_CHANNELS must be within 1..8");
    end
    if (_FIFO_DEPTH < 2 || (_FIFO_DEPTH & (_FIFO_DEPTH - 1)) != 0) begin : g_chk_depth
        $error("_FIFO_DEPTH must be a power of two >= 2");
    end
    if (_ACK_TIMEOUT < 1) begin : g_chk_tmo
        $error("_ACK_TIMEOUT must be >= 1");
    end

    seq_state_e             state_q, state_d;
    logic [7:0]             ch_r;
    logic [_GAP_WIDTH-1:0]  gap_r;
    logic [_GAP_WIDTH-1:0]  gap_cnt;
    logic [CW-1:0]          fifo_rd;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   fifo_push;
    logic                   fifo_pop;
    logic                   ch_ok;
    logic                   busy_sel;
    logic [_NUM_CHANNELS-1:0] start_vec;
    logic                   bad_drop;
    logic                   tmo_drop;

    assign cmd.cmd_ready = !fifo_full;
    assign fifo_push     = cmd.cmd_valid && !fifo_full;
    assign fifo_pop      = (state_q == IDLE) && !fifo_empty;

    pwm_seq_fifo #(
        .WIDTH (CW),
        .DEPTH (_FIFO_DEPTH)
    ) u_fifo (
        .clk_50M (clk_50M),
        .rst_n   (rst_n),
        .push    (fifo_push),
        .wr_data ({cmd.cmd_ch, cmd.cmd_gap}),
        .pop     (fifo_pop),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    // Only the busy flag of the working channel matters; a loop over valid
    // channels avoids indexing ch_busy with an out-of-range ch_r.
    always_comb begin
        busy_sel  = 1'b0;
        start_vec = '0;
        for (int i = 0; i < _NUM_CHANNELS; i++) begin
            if (ch_r == 8'(i)) begin
                busy_sel     = ch_busy[i];
                start_vec[i] = 1'b1;
            end
        end
    end

    assign ch_ok    = (ch_r < 8'(_NUM_CHANNELS));
    assign bad_drop = (state_q == CHECK) && !ch_ok;

`ifdef PWM_SEQ_ACK_TIMEOUT_EN
    localparam int TW = $clog2(_ACK_TIMEOUT + 1);

    logic [TW-1:0] ack_timer;
    logic          ack_expired;
    logic          err_timeout_q;

    // Timer counts completed WAIT_ACK cycles; the _ACK_TIMEOUT-th one aborts.
    assign ack_expired = (ack_timer == TW'(_ACK_TIMEOUT - 1));
    assign tmo_drop    = (state_q == WAIT_ACK) && !busy_sel && ack_expired;

    always_ff @(posedge clk_50M) begin
        if (!rst_n) begin
            ack_timer     <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            if (state_q == START) begin
                ack_timer <= '0;
            end else if (state_q == WAIT_ACK && !ack_expired) begin
                ack_timer <= ack_timer + 1'b1;
            end
            err_timeout_q <= tmo_drop;
        end
    end

    assign err_timeout = err_timeout_q;
`else
    assign tmo_drop    = 1'b0;
    assign err_timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (!fifo_empty) state_d = CHECK;
            CHECK: begin
                if (!ch_ok)         state_d = IDLE;
                else if (!busy_sel) state_d = START;
            end
            START:    state_d = WAIT_ACK;
            WAIT_ACK: begin
                if (busy_sel)      state_d = GAP;
                else if (tmo_drop) state_d = IDLE;
            end
            GAP:      if (gap_cnt == '0) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_50M) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ch_r       <= '0;
            gap_r      <= '0;
            gap_cnt    <= '0;
            ch_start   <= '0;
            err_bad_ch <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            state_q <= state_d;
            if (fifo_pop) begin
                {ch_r, gap_r} <= fifo_rd;
            end
            if (state_q == WAIT_ACK && busy_sel) begin
                gap_cnt <= gap_r;
            end else if (state_q == GAP && gap_cnt != '0) begin
                gap_cnt <= gap_cnt - 1'b1;
            end
            // Registered pulse: high exactly while the FSM sits in START.
            ch_start   <= (state_d == START) ? start_vec : '0;
            err_bad_ch <= bad_drop;
            if ((bad_drop || tmo_drop) && drop_cnt != DROP_CNT_MAX) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

    assign seq_busy = (state_q != IDLE) || !fifo_empty;

endmodule
